ahb_rr_burst_arbiter: RTL and testbench

// Round-robin, burst-aware arbiter sharing one AHB slave port between up to MASTER_NUM masters.
// - Tracks each owner's transfer stream through htrans/hburst/hready.
// - Holds the grant until a fixed-length burst completes, an INCR stream ends, or the owner releases.
// - Re-arbitrates on the edge where the last beat completes. Sits in front of the slave-side datapath mux.

---
 rtl/ahb_rr_burst_arbiter.sv | 166 ++++++++++++++++
 tb/tb_ahb_rr_burst_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_rr_burst_arbiter.sv
// ahb_rr_burst_arbiter
// Round-robin, burst-aware arbiter that shares one AHB slave port between
// MASTER_NUM masters. Once a master owns the port, its grant is held until
// one of three things happens: a SINGLE transfer completes, a fixed-length
// burst completes, or the owner ends an INCR stream (IDLE with its request
// dropped). Arbitration is repeated on the edge where that last beat
// completes.
//
// Ports
//   hclk_i     clock; all state updates on the rising edge
//   hreset_i   synchronous, active-high reset
//   hreq_i     per-master request
//   htrans_i   transfer type of the granted master (IDLE/BUSY/NONSEQ/SEQ)
//   hburst_i   burst type of the granted master
//   hready_i   slave ready; the current data phase completes this cycle
//   hgrant_o   registered one-hot grant; all zero when idle
//   hmaster_o  index of the granted master; 0 when idle
//   hsel_o     OR of hgrant_o
//   hlast_o    combinational; the last beat of a SINGLE or fixed burst
//              completes this cycle
module ahb_rr_burst_arbiter #(
  parameter int MASTER_NUM = 4,
  parameter int IDX_W      = $clog2(MASTER_NUM)
) (
  input  logic                  hclk_i,
  input  logic                  hreset_i,
  input  logic [MASTER_NUM-1:0] hreq_i,
  input  logic [1:0]            htrans_i,
  input  logic [2:0]            hburst_i,
  input  logic                  hready_i,
  output logic [MASTER_NUM-1:0] hgrant_o,
  output logic [IDX_W-1:0]      hmaster_o,
  output logic                  hsel_o,
  output logic                  hlast_o
);

  // state  | meaning
  // IDLE   | nobody granted
  // OWN    | granted, no burst in flight
  // BURST  | fixed-length burst in flight, counting beats
  // INCR   | undefined-length INCR stream in flight
  typedef enum logic [1:0] {ST_IDLE, ST_OWN, ST_BURST, ST_INCR} state_e;

  state_e                state_q, state_d;
  logic [MASTER_NUM-1:0] hgrant_q, hgrant_d;
  logic [IDX_W-1:0]      hmaster_q, hmaster_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [3:0]            limit_q, limit_d;

  logic                  win_vld;
  logic [IDX_W-1:0]      win_idx;
  logic [IDX_W-1:0]      cand;
  logic                  owner_req;
  logic                  beat;
  logic                  nonseq_beat;
  logic                  rearb;
  logic                  last_beat;

  assign hgrant_o  = hgrant_q;
  assign hmaster_o = hmaster_q;
  assign hsel_o    = |hgrant_q;

  assign owner_req   = hreq_i[hmaster_q];
  assign beat        = hsel_o & hready_i & htrans_i[1];
  assign nonseq_beat = beat & (htrans_i == 2'b10);

  // The search starts just after the last winner, so the current owner is
  // always the lowest-priority candidate.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 1; i <= MASTER_NUM; i++) begin
      cand = IDX_W'((int'(rr_ptr_q) + i) % MASTER_NUM);
      if (!win_vld && hreq_i[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    hgrant_d  = hgrant_q;
    hmaster_d = hmaster_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    limit_d   = limit_q;
    rearb     = 1'b0;
    last_beat = 1'b0;

    case (state_q)
      ST_IDLE: rearb = 1'b1;
      ST_OWN, ST_INCR: begin
        if (nonseq_beat) begin
          if (hburst_i == 3'b000) begin
            last_beat = 1'b1;
            rearb     = 1'b1;
          end else if (hburst_i == 3'b001) begin
            state_d = ST_INCR;
          end else begin
            // Store beats-1 so the terminal compare is a plain equality.
            case (hburst_i[2:1])
              2'b01:   limit_d = 4'd3;
              2'b10:   limit_d = 4'd7;
              default: limit_d = 4'd15;
            endcase
            cnt_d   = 4'd1;
            state_d = ST_BURST;
          end
        end else if (hready_i && htrans_i == 2'b00 && !owner_req) begin
          rearb = 1'b1;
        end
      end
      ST_BURST: begin
        if (beat) begin
          if (cnt_q == limit_q) begin
            last_beat = 1'b1;
            rearb     = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (rearb) begin
      cnt_d = '0;
      if (win_vld) begin
        hgrant_d          = '0;
        hgrant_d[win_idx] = 1'b1;
        hmaster_d         = win_idx;
        rr_ptr_d          = win_idx;
        state_d           = ST_OWN;
      end else begin
        hgrant_d  = '0;
        hmaster_d = '0;
        state_d   = ST_IDLE;
      end
    end
  end

  // A reset edge abandons whatever was in flight, so no completion is flagged.
  assign hlast_o = last_beat & ~hreset_i;

  always_ff @(posedge hclk_i) begin
    if (hreset_i) begin
      state_q   <= ST_IDLE;
      hgrant_q  <= '0;
      hmaster_q <= '0;
      rr_ptr_q  <= IDX_W'(MASTER_NUM - 1);
      cnt_q     <= '0;
      limit_q   <= '0;
    end else begin
      state_q   <= state_d;
      hgrant_q  <= hgrant_d;
      hmaster_q <= hmaster_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      limit_q   <= limit_d;
    end
  end

endmodule

// File: tb/tb_ahb_rr_burst_arbiter.sv
module tb_ahb_rr_burst_arbiter;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [1:0] tr;
  logic [2:0] bu;
  logic       rdy;
  logic [3:0] hgrant;
  logic [1:0] hmaster;
  logic       hsel;
  logic       hlast;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // reference model: owner (-1 = none), last winner, beats left in a fixed burst
  int m_owner;
  int m_rr;
  int m_left;

  logic [3:0] obs_grant;
  logic [1:0] obs_master;
  logic       obs_sel;
  logic       obs_last;
  logic [7:0] obs_vec;
  logic [7:0] exp_vec;

  ahb_rr_burst_arbiter #(.MASTER_NUM(4)) dut (
    .hclk_i   (clk),
    .hreset_i (rst),
    .hreq_i   (req),
    .htrans_i (tr),
    .hburst_i (bu),
    .hready_i (rdy),
    .hgrant_o (hgrant),
    .hmaster_o(hmaster),
    .hsel_o   (hsel),
    .hlast_o  (hlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Applies one cycle's inputs to the model; returns whether the model
  // expects the last beat of a transfer to complete this cycle.
  task automatic model_step(input logic r, input logic [3:0] q, input logic [1:0] t,
                            input logic [2:0] b, input logic y, output logic last);
    bit rel;
    last = 1'b0;
    rel  = 1'b0;
    if (r) begin
      m_owner = -1;
      m_rr    = 3;
      m_left  = 0;
      return;
    end
    if (m_owner < 0) begin
      rel = 1'b1;
    end else if (y) begin
      if (m_left > 0) begin
        if (t[1]) begin
          m_left--;
          if (m_left == 0) begin
            last = 1'b1;
            rel  = 1'b1;
          end
        end
      end else if (t == T_NSEQ) begin
        if (b == 3'b000) begin
          last = 1'b1;
          rel  = 1'b1;
        end else if (b != 3'b001) begin
          m_left = ((b[2:1] == 2'd1) ? 4 : (b[2:1] == 2'd2) ? 8 : 16) - 1;
        end
      end else if (t == T_IDLE && !q[m_owner]) begin
        rel = 1'b1;
      end
    end
    if (rel) begin
      m_owner = -1;
      m_left  = 0;
      for (int k = 1; k <= 4; k++) begin
        if (m_owner < 0 && q[(m_rr + k) % 4]) m_owner = (m_rr + k) % 4;
      end
      if (m_owner >= 0) m_rr = m_owner;
    end
  endtask

  task automatic tick(input logic r, input logic [3:0] q, input logic [1:0] t,
                      input logic [2:0] b, input logic y);
    logic       el;
    logic [3:0] eg;
    logic [1:0] em;
    logic       es;
    @(negedge clk);
    rst = r; req = q; tr = t; bu = b; rdy = y;
    #1;
    obs_grant  = hgrant;
    obs_master = hmaster;
    obs_sel    = hsel;
    obs_last   = hlast;
    obs_vec    = {obs_grant, obs_master, obs_sel, obs_last};
    eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    em = (m_owner < 0) ? 2'd0 : 2'(m_owner);
    es = (m_owner >= 0);
    model_step(r, q, t, b, y, el);
    exp_vec = {eg, em, es, el};
    @(posedge clk);
  endtask

  task automatic do_reset();
    tick(1'b1, 4'b0000, T_IDLE, 3'b000, 1'b1);
    tick(1'b1, 4'b0000, T_IDLE, 3'b000, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    tick(1'b0, 4'b0000, T_IDLE, 3'b000, 1'b1);
    total_cnt++;
    if (obs_vec !== 8'b0000_00_0_0) $display("FAIL reset_state got %b want %b", obs_vec, 8'b0);
    else pass_cnt++;
    total_cnt++;
    if (obs_vec !== exp_vec) $display("FAIL reset_model got %b want %b", obs_vec, exp_vec);
    else pass_cnt++;
  endtask

  task automatic test_single();
    do_reset();
    tick(1'b0, 4'b0001, T_IDLE, 3'b000, 1'b1);
    tick(1'b0, 4'b0001, T_NSEQ, 3'b000, 1'b1);
    total_cnt++;
    if (obs_grant !== 4'b0001 || obs_last !== 1'b1)
      $display("FAIL single_beat got g=%b l=%b want g=0001 l=1", obs_grant, obs_last);
    else pass_cnt++;
    tick(1'b0, 4'b0001, T_IDLE, 3'b000, 1'b1);
    total_cnt++;
    if (obs_grant !== 4'b0001 || obs_last !== 1'b0)
      $display("FAIL single_regrant got g=%b l=%b want g=0001 l=0", obs_grant, obs_last);
    else pass_cnt++;
    total_cnt++;
    if (obs_vec !== exp_vec) $display("FAIL single_model got %b want %b", obs_vec, exp_vec);
    else pass_cnt++;
  endtask

  task automatic test_rr_order();
    logic [3:0] order [5];
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    tick(1'b0, 4'b1111, T_NSEQ, 3'b000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 4'b1111, T_NSEQ, 3'b000, 1'b1);
      total_cnt++;
      if (obs_grant !== order[i] || obs_master !== 2'(i % 4) || obs_last !== 1'b1)
        $display("FAIL rr_order[%0d] got g=%b m=%0d l=%b want g=%b m=%0d l=1",
                 i, obs_grant, obs_master, obs_last, order[i], i % 4);
      else pass_cnt++;
    end
  endtask

  task automatic test_burst_wait();
    logic [1:0] t_tab [6];
    logic       r_tab [6];
    int         nlast;
    t_tab = '{T_NSEQ, T_SEQ, T_SEQ, T_SEQ, T_SEQ, T_SEQ};
    r_tab = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    nlast = 0;
    do_reset();
    tick(1'b0, 4'b0110, T_IDLE, 3'b000, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 4'b0110, t_tab[i], 3'b011, r_tab[i]);
      if (obs_last === 1'b1) nlast++;
      total_cnt++;
      if (obs_grant !== 4'b0010 || obs_last !== (i == 5) || obs_vec !== exp_vec)
        $display("FAIL burst_wait[%0d] got %b want %b (g=0010 l=%0d)", i, obs_vec, exp_vec, i == 5);
      else pass_cnt++;
    end
    tick(1'b0, 4'b0110, T_IDLE, 3'b000, 1'b1);
    total_cnt++;
    if (obs_grant !== 4'b0100 || nlast != 1)
      $display("FAIL burst_wait_next got g=%b nlast=%0d want g=0100 nlast=1", obs_grant, nlast);
    else pass_cnt++;
  endtask

  task automatic test_busy_incr16();
    int nbeat;
    int bad;
    bad = 0;
    do_reset();
    tick(1'b0, 4'b0001, T_IDLE, 3'b000, 1'b1);
    nbeat = 0;
    while (nbeat < 16) begin
      if (nbeat == 4 || nbeat == 9) begin
        tick(1'b0, 4'b0010, T_BUSY, 3'b111, 1'b1);
        if (obs_grant !== 4'b0001 || obs_last !== 1'b0 || obs_vec !== exp_vec) bad++;
      end
      nbeat++;
      tick(1'b0, (nbeat <= 3) ? 4'b0001 : 4'b0010, (nbeat == 1) ? T_NSEQ : T_SEQ, 3'b111, 1'b1);
      if (obs_grant !== 4'b0001 || obs_last !== (nbeat == 16) || obs_vec !== exp_vec) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL incr16_hold got %0d bad cycles want 0", bad);
    else pass_cnt++;
    tick(1'b0, 4'b0010, T_IDLE, 3'b000, 1'b1);
    total_cnt++;
    if (obs_grant !== 4'b0010) $display("FAIL incr16_next got g=%b want 0010", obs_grant);
    else pass_cnt++;
  endtask

  task automatic test_incr_stream();
    int bad;
    bad = 0;
    do_reset();
    tick(1'b0, 4'b1000, T_IDLE, 3'b000, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 4'b1000, (i == 0) ? T_NSEQ : T_SEQ, 3'b001, 1'b1);
      if (obs_grant !== 4'b1000 || obs_last !== 1'b0 || obs_vec !== exp_vec) bad++;
    end
    tick(1'b0, 4'b0001, T_IDLE, 3'b000, 1'b1);
    if (obs_grant !== 4'b1000 || obs_last !== 1'b0) bad++;
    total_cnt++;
    if (bad != 0) $display("FAIL incr_stream got %0d bad cycles want 0", bad);
    else pass_cnt++;
    tick(1'b0, 4'b0001, T_IDLE, 3'b000, 1'b1);
    total_cnt++;
    if (obs_grant !== 4'b0001) $display("FAIL incr_release got g=%b want 0001", obs_grant);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    tick(1'b0, 4'b0001, T_IDLE, 3'b000, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b0, 4'b0001, (i == 0) ? T_NSEQ : T_SEQ, 3'b100, 1'b1);
    tick(1'b1, 4'b0001, T_SEQ, 3'b100, 1'b1);
    total_cnt++;
    if (obs_last !== 1'b0 || obs_grant !== 4'b0001)
      $display("FAIL rst_mid_beat5 got g=%b l=%b want g=0001 l=0", obs_grant, obs_last);
    else pass_cnt++;
    tick(1'b0, 4'b1111, T_IDLE, 3'b000, 1'b1);
    total_cnt++;
    if (obs_grant !== 4'b0000 || obs_sel !== 1'b0)
      $display("FAIL rst_mid_after got g=%b s=%b want g=0000 s=0", obs_grant, obs_sel);
    else pass_cnt++;
    tick(1'b0, 4'b1111, T_NSEQ, 3'b011, 1'b1);
    total_cnt++;
    if (obs_grant !== 4'b0001) $display("FAIL rst_mid_regrant got g=%b want 0001", obs_grant);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 4'b1111, T_SEQ, 3'b011, 1'b1);
      total_cnt++;
      if (obs_last !== (i == 2) || obs_vec !== exp_vec)
        $display("FAIL rst_mid_incr4[%0d] got %b want %b", i, obs_vec, exp_vec);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    int bad;
    logic r;
    bad = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      tick(r, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
           3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
      if (obs_vec !== exp_vec) begin
        if (bad < 5) $display("FAIL random cycle %0d got %b want %b", i, obs_vec, exp_vec);
        bad++;
      end
    end
    total_cnt++;
    if (bad != 0) $display("FAIL random_total got %0d bad cycles want 0", bad);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; req = '0; tr = T_IDLE; bu = '0; rdy = 1'b1;
    m_owner = -1; m_rr = 3; m_left = 0;
    test_reset();
    test_single();
    test_rr_order();
    test_burst_wait();
    test_busy_incr16();
    test_incr_stream();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
